// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-way main-memory arbiter: requester indices,
// the "no owner" code, the FSM state type and the round-robin step helper.
package mem_arb_pkg;

  localparam logic [1:0] REQ_LDR    = 2'd0;
  localparam logic [1:0] REQ_CPU    = 2'd1;
  localparam logic [1:0] REQ_UART   = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  // Next requester index in rotation, wrapping 2 -> 0.
  function automatic logic [1:0] rr_inc(input logic [1:0] idx);
    return (idx >= REQ_UART) ? REQ_LDR : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bundle of the memory arbiter: per-requester request/write
// lanes in, grant/read-valid/read-data/owner out.
interface mem_arb_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic [2:0]      req_i;
  logic [2:0]      we_i;
  logic [3*AW-1:0] ad_i;
  logic [3*DW-1:0] wd_i;
  logic [2:0]      gnt_o;
  logic [2:0]      rvalid_o;
  logic [DW-1:0]   rd_o;
  logic [1:0]      owner_o;

  modport master (
    output req_i, we_i, ad_i, wd_i,
    input  gnt_o, rvalid_o, rd_o, owner_o
  );

  modport slave (
    input  req_i, we_i, ad_i, wd_i,
    output gnt_o, rvalid_o, rd_o, owner_o
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational 3-way round-robin picker: the first requesting index after
// i_last (mod 3) wins; o_found is low when nothing requests.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_winner,
  output logic       o_found
);

  logic [1:0] w_c1, w_c2, w_c3;

  assign w_c1 = rr_inc(i_last);
  assign w_c2 = rr_inc(w_c1);
  assign w_c3 = rr_inc(w_c2);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    o_winner = OWNER_NONE;
    o_found  = 1'b0;
    if (i_req[w_c1]) begin
      o_winner = w_c1;
      o_found  = 1'b1;
    end else if (i_req[w_c2]) begin
      o_winner = w_c2;
      o_found  = 1'b1;
    end else if (i_req[w_c3]) begin
      o_winner = w_c3;
      o_found  = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing memory port A between loader, CPU and UART.
// Define MEM_ARB_BURST_LIMIT_EN to revoke a grant after BURST_MAX beats when others wait.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW        = 19,
  parameter int DW        = 8,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_if.slave      bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  state_t     r_state;
  logic [1:0] r_owner;
  logic [1:0] r_last;
  logic [2:0] r_gnt;
  logic [2:0] r_rvalid;

  logic       w_beat;
  logic       w_own_we;
  logic       w_revoke;
  logic       w_arb;
  logic [1:0] w_winner;
  logic       w_found;

  // r_gnt is one-hot or zero, so masking avoids indexing with OWNER_NONE.
  assign w_beat   = |(r_gnt & bus.req_i);
  assign w_own_we = |(r_gnt & bus.we_i);
  assign w_arb    = (r_state == IDLE) || !w_beat || w_revoke;

  rr_pick u_pick (
    .i_req    (bus.req_i),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

`ifdef MEM_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(BURST_MAX) + 1;
  logic [CW-1:0] r_cnt;

  assign w_revoke = w_beat && (r_cnt >= CW'(BURST_MAX - 1)) && |(bus.req_i & ~r_gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_arb) begin
      r_cnt <= '0;
    end else if (w_beat && (r_cnt < CW'(BURST_MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  wire w_unused_burst_max = (BURST_MAX > 0);
  assign w_revoke = 1'b0;
`endif

  // Single FSM block; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWNER_NONE;
      r_last   <= REQ_UART;
      r_gnt    <= 3'b000;
      r_rvalid <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_rvalid <= (w_beat && !w_own_we) ? r_gnt : 3'b000;
      if (w_arb) begin
        if (w_found) begin
          r_state <= OWN;
          r_owner <= w_winner;
          r_last  <= w_winner;
          r_gnt   <= 3'b001 << w_winner;
        end else begin
          r_state <= IDLE;
          r_owner <= OWNER_NONE;
          r_gnt   <= 3'b000;
        end
      end
    end
  end

  always_comb begin
    mem_ad = '0;
    mem_wd = '0;
    case (r_owner)
      REQ_LDR: begin
        mem_ad = bus.ad_i[0*AW +: AW];
        mem_wd = bus.wd_i[0*DW +: DW];
      end
      REQ_CPU: begin
        mem_ad = bus.ad_i[1*AW +: AW];
        mem_wd = bus.wd_i[1*DW +: DW];
      end
      REQ_UART: begin
        mem_ad = bus.ad_i[2*AW +: AW];
        mem_wd = bus.wd_i[2*DW +: DW];
      end
      default: ;
    endcase
  end

  assign mem_we       = w_beat && w_own_we;
  assign bus.gnt_o    = r_gnt;
  assign bus.rvalid_o = r_rvalid;
  assign bus.owner_o  = r_owner;
  assign bus.rd_o     = mem_rd;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a small synchronous memory model.
// Honours MEM_ARB_BURST_LIMIT_EN when choosing the burst-cap expectation.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW        = 19;
  localparam int DW        = 8;
  localparam int BURST_MAX = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          tb_we = 1'b0;
  logic [7:0]    tb_ad = '0;
  logic [7:0]    tb_wd = '0;
  logic [7:0]    mem [256];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arb #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .mem_we (mem_we),
    .mem_ad (mem_ad),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_ad[7:0]] <= mem_wd;
    else if (tb_we) mem[tb_ad] <= tb_wd;
    mem_rd <= mem[mem_ad[7:0]];
  end

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic req, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.req_i[k]           = req;
    bus.we_i[k]            = we;
    bus.ad_i[k*AW +: AW]   = ad;
    bus.wd_i[k*DW +: DW]   = wd;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int ldr, uart, ldr_at_switch, cyc, we_base;
    logic [2:0] prev_gnt;

    bus.req_i = '0;
    bus.we_i  = '0;
    bus.ad_i  = '0;
    bus.wd_i  = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt",    32'(bus.gnt_o),    32'h0);
    check("rst_owner",  32'(bus.owner_o),  32'h3);
    check("rst_mem_we", 32'(mem_we),       32'h0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    tb_we = 1'b1; tb_ad = 8'h10; tb_wd = 8'hA5;
    step();
    tb_we = 1'b0;
    #3 rst_n = 1'b1;
    step();
    step();
    check("idle_gnt",    32'(bus.gnt_o),    32'h0);
    check("idle_owner",  32'(bus.owner_o),  32'h3);
    check("idle_rvalid", 32'(bus.rvalid_o), 32'h0);
    check("idle_mem_we", 32'(mem_we),       32'h0);

    // Single CPU read of 0x00010
    set_req(1, 1'b1, 1'b0, 19'h00010, 8'h00);
    step();
    check("rd_gnt",    32'(bus.gnt_o),   32'h2);
    check("rd_owner",  32'(bus.owner_o), 32'h1);
    check("rd_mem_ad", 32'(mem_ad),      32'h10);
    check("rd_mem_we", 32'(mem_we),      32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 19'h00010, 8'h00);
    check("rd_rvalid", 32'(bus.rvalid_o), 32'h2);
    check("rd_data",   32'(bus.rd_o),     32'hA5);
    step();
    check("rd_rel_gnt",    32'(bus.gnt_o),    32'h0);
    check("rd_rel_owner",  32'(bus.owner_o),  32'h3);
    check("rd_rel_rvalid", 32'(bus.rvalid_o), 32'h0);

    // Simultaneous requests after reset: loader, CPU, UART, 2 beats each
    pulse_reset();
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, 1'b0, 19'(32 * (k + 1)), 8'h00);
    step();
    check("sim_ldr_g1", 32'(bus.gnt_o), 32'h1);
    step();
    check("sim_ldr_g2", 32'(bus.gnt_o), 32'h1);
    step();
    bus.req_i[0] = 1'b0;
    check("sim_ldr_rel", 32'(bus.gnt_o), 32'h1);
    step();
    check("sim_cpu_g1", 32'(bus.gnt_o), 32'h2);
    step();
    step();
    bus.req_i[1] = 1'b0;
    check("sim_cpu_rel", 32'(bus.gnt_o), 32'h2);
    step();
    check("sim_uart_g1", 32'(bus.gnt_o), 32'h4);
    step();
    step();
    bus.req_i[2] = 1'b0;
    step();
    check("sim_end_gnt",   32'(bus.gnt_o),   32'h0);
    check("sim_end_owner", 32'(bus.owner_o), 32'h3);

    // Loader write burst 0x11,0x22,0x33 to 0..2
    we_base = we_cnt;
    set_req(0, 1'b1, 1'b1, 19'h0, 8'h11);
    step();
    check("wr_gnt",    32'(bus.gnt_o), 32'h1);
    check("wr_mem_we", 32'(mem_we),    32'h1);
    check("wr_mem_wd", 32'(mem_wd),    32'h11);
    step();
    set_req(0, 1'b1, 1'b1, 19'h1, 8'h22);
    step();
    set_req(0, 1'b1, 1'b1, 19'h2, 8'h33);
    step();
    set_req(0, 1'b0, 1'b0, 19'h0, 8'h00);
    step();
    check("wr_we_cycles", 32'(we_cnt - we_base), 32'd3);

    // CPU readback
    set_req(1, 1'b1, 1'b0, 19'h0, 8'h00);
    step();
    check("rb_gnt", 32'(bus.gnt_o), 32'h2);
    step();
    set_req(1, 1'b1, 1'b0, 19'h1, 8'h00);
    check("rb_rv0", 32'(bus.rvalid_o), 32'h2);
    check("rb_d0",  32'(bus.rd_o),     32'h11);
    step();
    set_req(1, 1'b1, 1'b0, 19'h2, 8'h00);
    check("rb_rv1", 32'(bus.rvalid_o), 32'h2);
    check("rb_d1",  32'(bus.rd_o),     32'h22);
    step();
    set_req(1, 1'b0, 1'b0, 19'h0, 8'h00);
    check("rb_rv2", 32'(bus.rvalid_o), 32'h2);
    check("rb_d2",  32'(bus.rd_o),     32'h33);
    step();
    check("rb_rv_end", 32'(bus.rvalid_o), 32'h0);

    // Burst cap: loader wants 40 beats, UART waits from cycle 1 for 3 beats
    pulse_reset();
    set_req(0, 1'b1, 1'b0, 19'h40, 8'h00);
    step();
    check("cap_ldr_g", 32'(bus.gnt_o), 32'h1);
    set_req(2, 1'b1, 1'b0, 19'h50, 8'h00);
    ldr = 0; uart = 0; ldr_at_switch = -1; cyc = 0;
    prev_gnt = 3'b000;
    while (!(ldr == 40 && uart == 3) && cyc < 300) begin
      #1;
      if (bus.gnt_o == 3'b100 && ldr_at_switch < 0) begin
        ldr_at_switch = ldr;
        check("cap_no_gap", 32'(prev_gnt), 32'h1);
      end
      if (bus.gnt_o[0] && bus.req_i[0]) ldr++;
      if (bus.gnt_o[2] && bus.req_i[2]) uart++;
      prev_gnt = bus.gnt_o;
      step();
      cyc++;
      if (ldr == 40) bus.req_i[0] = 1'b0;
      if (uart == 3) bus.req_i[2] = 1'b0;
    end
    check("cap_in_budget", 32'(cyc < 300), 32'h1);
`ifdef MEM_ARB_BURST_LIMIT_EN
    check("cap_ldr_first", 32'(ldr_at_switch), 32'(BURST_MAX));
`else
    check("cap_ldr_first", 32'(ldr_at_switch), 32'd40);
`endif
    check("cap_ldr_total",  32'(ldr),  32'd40);
    check("cap_uart_total", 32'(uart), 32'd3);
    step();
    step();
    check("cap_end_gnt", 32'(bus.gnt_o), 32'h0);

    // Asynchronous reset while UART owns with a write
    set_req(2, 1'b1, 1'b1, 19'h5, 8'h77);
    step();
    check("ar_gnt_pre",    32'(bus.gnt_o), 32'h4);
    check("ar_mem_we_pre", 32'(mem_we),    32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt",    32'(bus.gnt_o),   32'h0);
    check("ar_owner",  32'(bus.owner_o), 32'h3);
    check("ar_mem_we", 32'(mem_we),      32'h0);
    set_req(0, 1'b1, 1'b0, 19'h0, 8'h00);
    #2 rst_n = 1'b1;
    step();
    check("ar_ldr_first", 32'(bus.gnt_o), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
